lbist_ctrl_mc: RTL

//  Multi-chain LBIST sequencer, successor to the single-capture LBIST core. Drives SCW scan chains

---
 rtl/lbist_ctrl_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lbist_ctrl_mc.sv
// lbist_ctrl_mc: multi-chain LBIST sequencer (Galois PRPG -> SCW chains, 1-4 captures, MISR signature).
// Revision: 1.0
`default_nettype none

module lbist_ctrl_mc #(
  parameter int          SCW       = 8,
  parameter int          CW        = 16,
  parameter logic [31:0] PRPG_POLY = 32'h0040_0007,
  parameter logic [31:0] MISR_POLY = 32'h0040_0007
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic           srst,
  input  logic           lbist_start,
  input  logic [CW-1:0]  cfg_lbist_pat,
  input  logic [CW-1:0]  cfg_chain_depth,
  input  logic [1:0]     cfg_capture_cnt,
  input  logic [31:0]    cfg_seed,
  input  logic [31:0]    cfg_exp_sig,
  output logic           lbist_busy,
  output logic           lbist_done,
  output logic           lbist_pass,
  output logic [31:0]    lbist_sig,
  output logic           scan_clk_en,
  output logic           scan_rst_n,
  output logic           scan_mode,
  output logic           scan_en,
  output logic [SCW-1:0] scan_in,
  input  logic [SCW-1:0] scan_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CSETUP  = 3'd3,
    S_CAPTURE = 3'd4,
    S_CHOLD   = 3'd5,
    S_UNLOAD  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t          r_state;
  logic            r_start_d;
  logic [31:0]     r_prpg;
  logic [31:0]     r_sig;
  logic [CW-1:0]   r_pat;
  logic [CW-1:0]   r_depth;
  logic [1:0]      r_cap;
  logic [31:0]     r_exp;
  logic [CW-1:0]   r_pat_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_scan_clk_en;
  logic            r_scan_rst_n;
  logic            r_scan_mode;
  logic            r_scan_en;
  logic [SCW-1:0]  r_scan_in;

  logic            w_start_edge;
  logic [31:0]     w_seed_eff;
  logic [CW-1:0]   w_depth_eff;
  logic [31:0]     w_prpg_next;
  logic [31:0]     w_misr_next;
  logic [31:0]     w_so_ext;
  logic [31:0]     w_src;
  logic [SCW-1:0]  w_chain;
  logic [CW-1:0]   w_pat_inc;

  assign w_start_edge = lbist_start & ~r_start_d;
  assign w_seed_eff   = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
  assign w_depth_eff  = (cfg_chain_depth == '0) ? C_ONE : cfg_chain_depth;
  assign w_prpg_next  = {r_prpg[30:0], 1'b0} ^ (r_prpg[31] ? PRPG_POLY : 32'h0);
  assign w_misr_next  = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_so_ext;
  assign w_pat_inc    = r_pat_idx + C_ONE;

  // scan_in is registered, so it is computed from the PRPG value the next SHIFT cycle will hold
  always_comb begin
    w_so_ext = '0;
    w_so_ext[SCW-1:0] = scan_out;
    w_src = r_prpg;
    if (r_state == S_INIT) begin
      w_src = w_seed_eff;
    end else if (r_state == S_SHIFT) begin
      w_src = w_prpg_next;
    end
  end

  for (genvar g = 0; g < SCW; g++) begin : g_chain
    assign w_chain[g] = w_src[g] ^ w_src[(g + SCW) % 32];
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_start_d     <= 1'b0;
      r_prpg        <= 32'h0;
      r_sig         <= 32'h0;
      r_pat         <= '0;
      r_depth       <= '0;
      r_cap         <= 2'd0;
      r_exp         <= 32'h0;
      r_pat_idx     <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_scan_clk_en <= 1'b0;
      r_scan_rst_n  <= 1'b1;
      r_scan_mode   <= 1'b0;
      r_scan_en     <= 1'b0;
      r_scan_in     <= '0;
    end else if (srst) begin
      r_state       <= S_IDLE;
      r_start_d     <= lbist_start;
      r_prpg        <= 32'h0;
      r_sig         <= 32'h0;
      r_pat_idx     <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_scan_clk_en <= 1'b0;
      r_scan_rst_n  <= 1'b1;
      r_scan_mode   <= 1'b0;
      r_scan_en     <= 1'b0;
      r_scan_in     <= '0;
    end else begin
      r_start_d <= lbist_start;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            r_state      <= S_INIT;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_sig        <= 32'h0;
            r_scan_mode  <= 1'b1;
            r_scan_rst_n <= 1'b0;
          end
        end
        S_INIT: begin
          r_pat        <= cfg_lbist_pat;
          r_depth      <= w_depth_eff;
          r_cap        <= cfg_capture_cnt;
          r_exp        <= cfg_exp_sig;
          r_prpg       <= w_seed_eff;
          r_sig        <= 32'h0;
          r_pat_idx    <= '0;
          r_scan_rst_n <= 1'b1;
          if (cfg_lbist_pat == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_scan_mode <= 1'b0;
            r_pass      <= (cfg_exp_sig == 32'h0);
          end else begin
            r_state       <= S_SHIFT;
            r_scan_en     <= 1'b1;
            r_scan_clk_en <= 1'b1;
            r_scan_in     <= w_chain;
            r_cnt         <= w_depth_eff - C_ONE;
          end
        end
        S_SHIFT: begin
          r_prpg <= w_prpg_next;
          // first load has no prior capture to unload
          if (r_pat_idx != '0) begin
            r_sig <= w_misr_next;
          end
          if (r_cnt == '0) begin
            r_state       <= S_CSETUP;
            r_scan_en     <= 1'b0;
            r_scan_clk_en <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - C_ONE;
            r_scan_in <= w_chain;
          end
        end
        S_CSETUP: begin
          r_state       <= S_CAPTURE;
          r_scan_clk_en <= 1'b1;
          r_cnt         <= CW'(r_cap);
        end
        S_CAPTURE: begin
          if (r_cnt == '0) begin
            r_state       <= S_CHOLD;
            r_scan_en     <= 1'b1;
            r_scan_clk_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_CHOLD: begin
          r_pat_idx     <= w_pat_inc;
          r_cnt         <= r_depth - C_ONE;
          r_scan_clk_en <= 1'b1;
          if (w_pat_inc == r_pat) begin
            r_state   <= S_UNLOAD;
            r_scan_in <= '0;
          end else begin
            r_state   <= S_SHIFT;
            r_scan_in <= w_chain;
          end
        end
        S_UNLOAD: begin
          r_sig <= w_misr_next;
          if (r_cnt == '0) begin
            r_state       <= S_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_scan_mode   <= 1'b0;
            r_scan_en     <= 1'b0;
            r_scan_clk_en <= 1'b0;
            r_pass        <= (w_misr_next == r_exp);
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lbist_busy  = r_busy;
  assign lbist_done  = r_done;
  assign lbist_pass  = r_pass;
  assign lbist_sig   = r_sig;
  assign scan_clk_en = r_scan_clk_en;
  assign scan_rst_n  = r_scan_rst_n;
  assign scan_mode   = r_scan_mode;
  assign scan_en     = r_scan_en;
  assign scan_in     = r_scan_in;

endmodule

`default_nettype wire
